// File: rtl/irq_ctrl_pkg.sv
// Shared constants, types and helpers for the MMIO interrupt controller.
package irq_ctrl_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned OFF_W       = 5;
    localparam int unsigned ID_W        = 5;
    localparam int unsigned MAX_NUM_SRC = 31;

    localparam logic [OFF_W-1:0] OFF_PENDING  = 5'h00;
    localparam logic [OFF_W-1:0] OFF_ENABLE   = 5'h04;
    localparam logic [OFF_W-1:0] OFF_EDGE     = 5'h08;
    localparam logic [OFF_W-1:0] OFF_CLAIM    = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_COMPLETE = 5'h10;

    // Decoded bus access for the current cycle.
    typedef struct packed {
        logic             rd_latch;
        logic             wr_commit;
        logic [OFF_W-1:0] off;
    } mmio_cmd_t;

    // ID (index+1) of the lowest set bit, 0 when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_id(input logic [MAX_NUM_SRC-1:0] vec);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = int'(MAX_NUM_SRC) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i + 1);
            end
        end
        return id;
    endfunction

    // Expand byte strobes into a per-bit write mask.
    function automatic logic [DATA_W-1:0] strobe_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input synchronizer with previous-value flop and rising-edge detect.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic level_c,
    output logic rise_c
);

    logic prev_q;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign level_c = d;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync_q <= '0;
            end else begin
                sync_q <= SYNC_STAGES'({sync_q, d});
            end
        end

        assign level_c = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_c;
        end
    end

    assign rise_c = level_c & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// MMIO interrupt controller: per-source level/edge pending, enable mask,
// lowest-index-first claim/complete handshake and a registered CPU IRQ line.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               mmio_valid,
    input  logic               mmio_write,
    input  logic [31:0]        mmio_addr,
    input  logic [31:0]        mmio_wdata,
    input  logic [3:0]         mmio_wstrb,
    output logic [31:0]        mmio_rdata,
    output logic               mmio_ready,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_out
);

    logic [NUM_SRC-1:0] src_level_c;
    logic [NUM_SRC-1:0] src_rise_c;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .resetn (resetn),
            .d      (irq_src[i]),
            .level_c(src_level_c[i]),
            .rise_c (src_rise_c[i])
        );
    end

    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] in_service_q;

    // Bus decode: reads latch on the first valid cycle, writes commit on the ready cycle.
    mmio_cmd_t cmd_c;
    always_comb begin
        cmd_c           = '0;
        cmd_c.rd_latch  = mmio_valid & ~mmio_write & ~mmio_ready;
        cmd_c.wr_commit = mmio_valid & mmio_write & mmio_ready;
        cmd_c.off       = mmio_addr[OFF_W-1:0];
    end

    logic wr_pending_c;
    logic wr_enable_c;
    logic wr_edge_c;
    logic wr_complete_c;
    logic claim_c;

    assign wr_pending_c  = cmd_c.wr_commit & (cmd_c.off == OFF_PENDING);
    assign wr_enable_c   = cmd_c.wr_commit & (cmd_c.off == OFF_ENABLE);
    assign wr_edge_c     = cmd_c.wr_commit & (cmd_c.off == OFF_EDGE);
    assign wr_complete_c = cmd_c.wr_commit & (cmd_c.off == OFF_COMPLETE) & mmio_wstrb[0];
    assign claim_c       = cmd_c.rd_latch & (cmd_c.off == OFF_CLAIM);

    // Priority: lowest eligible index wins; winner_c is its one-hot.
    logic [NUM_SRC-1:0] eligible_c;
    logic [NUM_SRC-1:0] winner_c;
    logic [ID_W-1:0]    claim_id_c;

    assign eligible_c = pending_q & enable_q & ~in_service_q;
    assign winner_c   = eligible_c & (~eligible_c + NUM_SRC'(1));
    assign claim_id_c = lowest_id(MAX_NUM_SRC'(eligible_c));

    logic [DATA_W-1:0] byte_mask_c;
    logic [DATA_W-1:0] enable_wide_c;
    logic [DATA_W-1:0] edge_wide_c;

    assign byte_mask_c   = strobe_mask(mmio_wstrb);
    assign enable_wide_c = (DATA_W'(enable_q) & ~byte_mask_c) | (mmio_wdata & byte_mask_c);
    assign edge_wide_c   = (DATA_W'(edge_q) & ~byte_mask_c) | (mmio_wdata & byte_mask_c);

    logic [NUM_SRC-1:0] complete_c;
    always_comb begin
        complete_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            complete_c[i] = (mmio_wdata[ID_W-1:0] == ID_W'(i + 1));
        end
    end

    logic [NUM_SRC-1:0] edge_n_c;
    logic [NUM_SRC-1:0] mode_chg_c;
    logic [NUM_SRC-1:0] edge_clr_c;
    logic [NUM_SRC-1:0] pending_n_c;
    logic [NUM_SRC-1:0] in_service_n_c;

    // Mode change discards the latch; edge set beats claim/W1C clear; level tracks input.
    always_comb begin
        edge_n_c       = wr_edge_c ? edge_wide_c[NUM_SRC-1:0] : edge_q;
        mode_chg_c     = edge_n_c ^ edge_q;
        edge_clr_c     = ({NUM_SRC{claim_c}} & winner_c)
                       | ({NUM_SRC{wr_pending_c}} & mmio_wdata[NUM_SRC-1:0]);
        pending_n_c    = ~mode_chg_c
                       & ((edge_q & (src_rise_c | (pending_q & ~edge_clr_c)))
                       | (~edge_q & src_level_c));
        in_service_n_c = (in_service_q | ({NUM_SRC{claim_c}} & winner_c))
                       & ~({NUM_SRC{wr_complete_c}} & complete_c);
    end

    logic [DATA_W-1:0] rdata_c;
    always_comb begin
        rdata_c = '0;
        case (cmd_c.off)
            OFF_PENDING: rdata_c = DATA_W'(pending_q);
            OFF_ENABLE:  rdata_c = DATA_W'(enable_q);
            OFF_EDGE:    rdata_c = DATA_W'(edge_q);
            OFF_CLAIM:   rdata_c = DATA_W'(claim_id_c);
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q    <= '0;
            enable_q     <= '0;
            edge_q       <= '0;
            in_service_q <= '0;
            mmio_rdata   <= '0;
            mmio_ready   <= 1'b0;
            irq_out      <= 1'b0;
        end else begin
            mmio_ready   <= mmio_valid & ~mmio_ready;
            if (cmd_c.rd_latch) begin
                mmio_rdata <= rdata_c;
            end
            if (wr_enable_c) begin
                enable_q <= enable_wide_c[NUM_SRC-1:0];
            end
            edge_q       <= edge_n_c;
            pending_q    <= pending_n_c;
            in_service_q <= in_service_n_c;
            irq_out      <= |eligible_c;
        end
    end

    // Address bits above the decoded window and register bits above NUM_SRC are don't-care.
    logic unused_bits;
    assign unused_bits = ^{mmio_addr[DATA_W-1:OFF_W],
                           enable_wide_c[DATA_W-1:NUM_SRC],
                           edge_wide_c[DATA_W-1:NUM_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// bus/source traffic compared against a transaction-level reference model.
module tb_irq_controller;

    localparam int NS = 8;
    localparam int SS = 2;
    localparam logic [31:0] BASE   = 32'h8000_0040;
    localparam logic [4:0]  O_PEND = 5'h00;
    localparam logic [4:0]  O_EN   = 5'h04;
    localparam logic [4:0]  O_EDGE = 5'h08;
    localparam logic [4:0]  O_CLM  = 5'h0C;
    localparam logic [4:0]  O_CMP  = 5'h10;

    logic          clk;
    logic          resetn;
    logic          mmio_valid;
    logic          mmio_write;
    logic [31:0]   mmio_addr;
    logic [31:0]   mmio_wdata;
    logic [3:0]    mmio_wstrb;
    logic [31:0]   mmio_rdata;
    logic          mmio_ready;
    logic [NS-1:0] irq_src;
    logic          irq_out;

    int n_vec;
    int n_err;

    irq_controller #(
        .NUM_SRC    (NS),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mmio_valid(mmio_valid),
        .mmio_write(mmio_write),
        .mmio_addr (mmio_addr),
        .mmio_wdata(mmio_wdata),
        .mmio_wstrb(mmio_wstrb),
        .mmio_rdata(mmio_rdata),
        .mmio_ready(mmio_ready),
        .irq_src   (irq_src),
        .irq_out   (irq_out)
    );

    always #5 clk = ~clk;

    // Reference model state: two-deep sample history of the sources, plus the
    // architectural registers as seen by software.
    typedef struct packed {
        logic [NS-1:0] hist0;
        logic [NS-1:0] hist1;
        logic [NS-1:0] prev;
        logic [NS-1:0] pend;
        logic [NS-1:0] en;
        logic [NS-1:0] edg;
        logic [NS-1:0] insvc;
        logic          irq;
        logic          ready;
        logic [31:0]   rdata;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t ref_step(input mstate_t c, input logic valid, input logic write,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         input logic [3:0] wstrb, input logic [NS-1:0] src);
        mstate_t       n;
        int            win;
        int            id;
        logic [4:0]    off;
        logic [NS-1:0] s;
        logic          rd;
        logic          wr;
        n   = c;
        s   = c.hist1;
        off = addr[4:0];
        rd  = valid && !write && !c.ready;
        wr  = valid && write && c.ready;
        win = -1;
        for (int i = 0; i < NS; i++)
            if (win < 0 && c.pend[i] && c.en[i] && !c.insvc[i]) win = i;
        if (rd) begin
            case (off)
                O_PEND: n.rdata = 32'(c.pend);
                O_EN:   n.rdata = 32'(c.en);
                O_EDGE: n.rdata = 32'(c.edg);
                O_CLM: begin
                    n.rdata = 32'(win + 1);
                    if (win >= 0) begin
                        n.insvc[win] = 1'b1;
                        if (c.edg[win]) n.pend[win] = 1'b0;
                    end
                end
                default: n.rdata = 32'h0;
            endcase
        end
        if (wr) begin
            case (off)
                O_PEND: for (int i = 0; i < NS; i++) if (wdata[i] && c.edg[i]) n.pend[i] = 1'b0;
                O_EN:   for (int i = 0; i < NS; i++) if (wstrb[i/8]) n.en[i] = wdata[i];
                O_EDGE: for (int i = 0; i < NS; i++) if (wstrb[i/8]) n.edg[i] = wdata[i];
                O_CMP: begin
                    id = int'(wdata[4:0]);
                    if (wstrb[0] && id >= 1 && id <= NS) n.insvc[id-1] = 1'b0;
                end
                default: ;
            endcase
        end
        for (int i = 0; i < NS; i++) begin
            if (n.edg[i] != c.edg[i]) n.pend[i] = 1'b0;
            else if (c.edg[i]) begin
                if (s[i] && !c.prev[i]) n.pend[i] = 1'b1;
            end else n.pend[i] = s[i];
        end
        n.irq   = (win >= 0);
        n.prev  = s;
        n.hist1 = c.hist0;
        n.hist0 = src;
        n.ready = valid && !c.ready;
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= '0;
        else m <= ref_step(m, mmio_valid, mmio_write, mmio_addr, mmio_wdata, mmio_wstrb, irq_src);
    end

    task automatic mmio_wr(input logic [4:0] off, input logic [31:0] data, input logic [3:0] strb);
        mmio_addr  = BASE | 32'(off);
        mmio_wdata = data;
        mmio_wstrb = strb;
        mmio_write = 1'b1;
        mmio_valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mmio_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_ready off=%h got %b want 1", off, mmio_ready);
        end
        @(negedge clk);
        mmio_valid = 1'b0;
        mmio_write = 1'b0;
    endtask

    task automatic mmio_rd(input logic [4:0] off, output logic [31:0] data);
        mmio_addr  = BASE | 32'(off);
        mmio_write = 1'b0;
        mmio_valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mmio_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_ready off=%h got %b want 1", off, mmio_ready);
        end
        data       = mmio_rdata;
        mmio_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input int idx);
        irq_src[idx] = 1'b1;
        @(negedge clk);
        irq_src[idx] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        irq_src = '1;
        mmio_wr(O_EN, 32'hFF, 4'hF);
        mmio_wr(O_EDGE, 32'h0F, 4'hF);
        repeat (4) @(negedge clk);
        n_vec++;
        if (irq_out !== 1'b1 || irq_out !== m.irq) begin
            n_err++;
            $display("FAIL pre_reset_irq got %b want 1 (model %b)", irq_out, m.irq);
        end
        mmio_addr  = BASE | 32'(O_PEND);
        mmio_valid = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({irq_out, mmio_ready, mmio_rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_outputs got irq=%b rdy=%b rdata=%h want 0", irq_out, mmio_ready, mmio_rdata);
        end
        mmio_valid = 1'b0;
        irq_src    = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_pending got %h want 0", d); end
        mmio_rd(O_EN, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_enable got %h want 0", d); end
        mmio_rd(O_EDGE, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_edge got %h want 0", d); end
    endtask

    task automatic test_timer_level();
        logic [31:0] d;
        mmio_wr(O_EN, 32'h01, 4'hF);
        mmio_wr(O_EDGE, 32'h00, 4'hF);
        irq_src[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            n_vec++;
            if (irq_out !== (e == 4)) begin
                n_err++;
                $display("FAIL timer_latency edge=%0d got %b want %b", e, irq_out, (e == 4));
            end
        end
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd1) begin n_err++; $display("FAIL timer_claim got %h want 1", d); end
        n_vec++;
        if (irq_out !== 1'b0) begin n_err++; $display("FAIL timer_irq_after_claim got %b want 0", irq_out); end
        irq_src[0] = 1'b0;
        repeat (4) @(negedge clk);
        mmio_wr(O_CMP, 32'd1, 4'h1);
        repeat (4) @(negedge clk);
        n_vec++;
        if (irq_out !== 1'b0 || irq_out !== m.irq) begin
            n_err++;
            $display("FAIL timer_no_reassert got %b want 0 (model %b)", irq_out, m.irq);
        end
    endtask

    task automatic test_edge_latch();
        logic [31:0] d;
        mmio_wr(O_EDGE, 32'h04, 4'hF);
        mmio_wr(O_EN, 32'h04, 4'hF);
        pulse(2);
        repeat (4) @(negedge clk);
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h04) begin n_err++; $display("FAIL edge_pending_held got %h want 04", d); end
        n_vec++;
        if (irq_out !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b want 1", irq_out); end
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd3) begin n_err++; $display("FAIL edge_claim got %h want 3", d); end
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL edge_claim_clears got %h want 0", d); end
        pulse(2);
        repeat (4) @(negedge clk);
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h04) begin n_err++; $display("FAIL edge_repend got %h want 04", d); end
        n_vec++;
        if (irq_out !== 1'b0) begin n_err++; $display("FAIL edge_in_service_irq got %b want 0", irq_out); end
        mmio_wr(O_CMP, 32'd3, 4'h1);
        @(negedge clk);
        n_vec++;
        if (irq_out !== 1'b1) begin n_err++; $display("FAIL edge_after_complete got %b want 1", irq_out); end
        mmio_rd(O_CLM, d);
        mmio_wr(O_CMP, 32'd3, 4'h1);
    endtask

    task automatic test_priority();
        logic [31:0] d;
        mmio_wr(O_EDGE, 32'h22, 4'hF);
        mmio_wr(O_EN, 32'h22, 4'hF);
        irq_src = 8'h22;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (4) @(negedge clk);
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd2) begin n_err++; $display("FAIL prio_first got %h want 2", d); end
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd6) begin n_err++; $display("FAIL prio_second got %h want 6", d); end
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL prio_empty got %h want 0", d); end
        mmio_wr(O_CMP, 32'd7, 4'h1);
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd0 || irq_out !== 1'b0) begin
            n_err++;
            $display("FAIL prio_bad_complete got claim=%h irq=%b want 0/0", d, irq_out);
        end
        mmio_wr(O_CMP, 32'd2, 4'h1);
        mmio_wr(O_CMP, 32'd6, 4'h1);
    endtask

    task automatic test_mask_w1c();
        logic [31:0] d;
        mmio_wr(O_EN, 32'h00, 4'hF);
        mmio_wr(O_EDGE, 32'h08, 4'hF);
        pulse(3);
        repeat (4) @(negedge clk);
        n_vec++;
        if (irq_out !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b want 0", irq_out); end
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h08) begin n_err++; $display("FAIL mask_pending got %h want 08", d); end
        mmio_wr(O_PEND, 32'h08, 4'hF);
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL w1c_edge got %h want 0", d); end
        irq_src[4] = 1'b1;
        repeat (4) @(negedge clk);
        mmio_wr(O_PEND, 32'h10, 4'hF);
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h10) begin n_err++; $display("FAIL w1c_level got %h want 10", d); end
        irq_src[4] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_race();
        logic [31:0] d;
        mmio_wr(O_EDGE, 32'h04, 4'hF);
        mmio_wr(O_EN, 32'h04, 4'hF);
        pulse(2);
        repeat (4) @(negedge clk);
        irq_src[2] = 1'b1;
        repeat (2) @(negedge clk);
        mmio_rd(O_CLM, d);
        n_vec++;
        if (d !== 32'd3) begin n_err++; $display("FAIL race_claim got %h want 3", d); end
        mmio_rd(O_PEND, d);
        n_vec++;
        if (d !== 32'h04 || m.pend !== 8'h04) begin
            n_err++;
            $display("FAIL race_set_wins got %h want 04 (model %h)", d, m.pend);
        end
        irq_src[2] = 1'b0;
        mmio_wr(O_CMP, 32'd3, 4'h1);
        @(negedge clk);
        n_vec++;
        if (irq_out !== 1'b1) begin n_err++; $display("FAIL race_reassert got %b want 1", irq_out); end
        mmio_rd(O_CLM, d);
        mmio_wr(O_CMP, 32'd3, 4'h1);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [4:0]  off;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 1) == 0) irq_src = NS'($urandom);
            case ($urandom_range(0, 7))
                0: mmio_wr(O_EN, $urandom, 4'($urandom));
                1: mmio_wr(O_EDGE, $urandom, 4'($urandom));
                2: mmio_wr(O_PEND, $urandom, 4'hF);
                3: mmio_wr(O_CMP, 32'($urandom_range(0, 31)), 4'($urandom));
                4, 5: begin
                    mmio_rd(O_CLM, d);
                    n_vec++;
                    if (d !== m.rdata) begin
                        n_err++;
                        $display("FAIL rand_claim it=%0d got %h want %h", it, d, m.rdata);
                    end
                end
                6: begin
                    off = 5'($urandom_range(0, 7) * 4);
                    mmio_rd(off, d);
                    n_vec++;
                    if (d !== m.rdata) begin
                        n_err++;
                        $display("FAIL rand_read it=%0d off=%h got %h want %h", it, off, d, m.rdata);
                    end
                end
                default: @(negedge clk);
            endcase
            n_vec++;
            if (irq_out !== m.irq) begin
                n_err++;
                $display("FAIL rand_irq it=%0d got %b want %b", it, irq_out, m.irq);
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        clk        = 1'b0;
        resetn     = 1'b0;
        mmio_valid = 1'b0;
        mmio_write = 1'b0;
        mmio_addr  = BASE;
        mmio_wdata = '0;
        mmio_wstrb = '0;
        irq_src    = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_timer_level();
        test_edge_latch();
        test_priority();
        test_mask_w1c();
        test_race();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
